// File: rtl/permutator_drain.sv
// permutator_drain: captures permuted vectors into two banks and serializes
// their lanes onto a valid/ready word stream.
// Ports: clk, reset_n (sync, active low); t_vec_dat/len/valid/ready vector in;
// i_dat/i_lane/i_last/i_valid/i_ready word out; busy = any bank occupied.
// Option: PERMUTATOR_DRAIN_BITREV_EN emits full vectors in bit-reversed order.
module permutator_drain #(
   parameter int DATA_WIDTH  = 32,
   parameter int LOG2_SLICES = 4
) (
   input  logic                                    clk,
   input  logic                                    reset_n,
   input  logic [(1<<LOG2_SLICES)*DATA_WIDTH-1:0]  t_vec_dat,
   input  logic [LOG2_SLICES:0]                    t_vec_len,
   input  logic                                    t_vec_valid,
   output logic                                    t_vec_ready,
   output logic [DATA_WIDTH-1:0]                   i_dat,
   output logic [LOG2_SLICES-1:0]                  i_lane,
   output logic                                    i_last,
   output logic                                    i_valid,
   input  logic                                    i_ready,
   output logic                                    busy
);
   localparam int SLICES = 1 << LOG2_SLICES;
   localparam int LW     = LOG2_SLICES + 1;
   localparam logic [LW-1:0] LEN_MAX = LW'(SLICES);

   typedef enum logic {S_IDLE, S_DRAIN} state_e;

   state_e state_q, state_d;
   logic [SLICES*DATA_WIDTH-1:0] bank_q [2];
   logic [LW-1:0] len_q [2];
   logic wr_ptr_q, wr_ptr_d;
   logic rd_ptr_q, rd_ptr_d;
   logic [1:0] occ_q, occ_d;
   logic [LOG2_SLICES-1:0] lane_q, lane_d;
   logic [LOG2_SLICES-1:0] phys_lane;
   logic [LW-1:0] len_in;
   logic acc, store, hs, rel;

   assign t_vec_ready = reset_n & (occ_q != 2'd2);
   assign acc   = t_vec_valid & t_vec_ready;
   // A zero-length vector completes its handshake but is never stored.
   assign store = acc & (t_vec_len != '0);

`ifdef PERMUTATOR_DRAIN_BITREV_EN
   assign len_in = LEN_MAX;

   always_comb begin
      phys_lane = '0;
      for (int i = 0; i < LOG2_SLICES; i++)
         phys_lane[i] = lane_q[LOG2_SLICES-1-i];
   end
`else
   assign len_in = (t_vec_len > LEN_MAX) ? LEN_MAX : t_vec_len;
   assign phys_lane = lane_q;
`endif

   assign i_valid = (state_q == S_DRAIN);
   assign i_lane  = phys_lane;
   assign i_last  = i_valid &
                    ({1'b0, lane_q} == len_q[rd_ptr_q] - LW'(1));
   assign busy    = (occ_q != 2'd0);
   assign hs      = i_valid & i_ready;
   assign rel     = hs & i_last;

   always_comb begin
      i_dat = '0;
      for (int k = 0; k < SLICES; k++)
         if (phys_lane == LOG2_SLICES'(k))
            i_dat = bank_q[rd_ptr_q][k*DATA_WIDTH +: DATA_WIDTH];
   end

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q ^ store;
      rd_ptr_d = rd_ptr_q ^ rel;
      occ_d    = occ_q + {1'b0, store} - {1'b0, rel};
      lane_d   = lane_q;
      if (rel)
         lane_d = '0;
      else if (hs)
         lane_d = lane_q + LOG2_SLICES'(1);
      unique case (state_q)
         // A store this cycle starts draining next cycle: no idle bubble.
         S_IDLE:
            if (occ_q != 2'd0 || store)
               state_d = S_DRAIN;
         S_DRAIN:
            if (occ_d == 2'd0)
               state_d = S_IDLE;
         default:
            state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         occ_q    <= 2'd0;
         lane_q   <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         lane_q   <= lane_d;
      end
   end

   // Bank storage needs no reset; occupancy decides what is valid.
   always_ff @(posedge clk) begin
      if (store) begin
         bank_q[wr_ptr_q] <= t_vec_dat;
         len_q[wr_ptr_q]  <= len_in;
      end
   end

endmodule
